// File: rtl/spi_word_slave_pkg.sv
// Shared types and defaults for the SPI word slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_word_pkg;

  localparam int WORD_W_DEF      = 32;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_CYC_DEF = 4096;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  // Bit counter must hold 0..WORD_W-1 with one bit of headroom.
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/spi_word_slave_if.sv
// Pin-side SPI signals plus the command-decoder word bus.
// Latency: n/a (wiring only).
// Backpressure: none; SPI has no flow control, the MCU paces all transfers.
interface spi_word_slave_if
  import spi_word_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) ();

  logic              spi_cs_n;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [WORD_W-1:0] spi_inputvalue;
  logic [WORD_W-1:0] spi_outputvalue;
  logic              spi_dataouttrigger;
  logic              frame_err;

  modport slave (
    input  spi_cs_n, spi_sclk, spi_mosi, spi_inputvalue,
    output spi_miso, spi_miso_oe, spi_outputvalue, spi_dataouttrigger, frame_err
  );

  modport master (
    output spi_cs_n, spi_sclk, spi_mosi, spi_inputvalue,
    input  spi_miso, spi_miso_oe, spi_outputvalue, spi_dataouttrigger, frame_err
  );

endinterface

// File: rtl/spi_word_slave_sync_edge.sv
// N-stage synchroniser for one asynchronous pin with rise/fall detection.
// Latency: STAGES clk to sync output, edges flagged in the same cycle as sync changes.
// Backpressure: none.
module spi_sync_edge
  import spi_word_pkg::*;
#(
  parameter int   STAGES  = SYNC_STAGES_DEF,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              prev;
  // smp_ok[k] set once stage k holds a sample taken from the pin rather than
  // the reset value; edges are only reported between two genuine samples so
  // that a pin already at the opposite level after reset is never seen as an edge.
  logic [STAGES:0]   smp_ok;

  // Synchroniser chain, previous-value register and sample-validity tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr     <= {STAGES{RST_VAL}};
      prev   <= RST_VAL;
      smp_ok <= '0;
    end else begin
      sr     <= {sr[STAGES-2:0], din};
      prev   <= sr[STAGES-1];
      smp_ok <= {smp_ok[STAGES-1:0], 1'b1};
    end
  end

  assign sync = sr[STAGES-1];
  assign rise = smp_ok[STAGES] &  sr[STAGES-1] & ~prev;
  assign fall = smp_ok[STAGES] & ~sr[STAGES-1] &  prev;

endmodule

// File: rtl/spi_word_slave.sv
// SPI mode-0 word slave: oversampled MOSI deserialiser / MISO serialiser; SPI_TIMEOUT_EN adds an SCLK idle timeout.
// Latency: word available SYNC_STAGES+1 clk after its last SCLK rise; response is sent in the following word.
// Backpressure: none; the MCU paces transfers and the decoder must accept every trigger pulse.
module spi_word_slave
  import spi_word_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  spi_word_slave_if.slave  bus
);

  localparam int            CW       = cnt_w(WORD_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);

  logic cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_s;
  logic cs_sync_unused, sclk_sync_unused;
  logic [SYNC_STAGES-1:0] mosi_sr;

  state_t            state_q, state_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [WORD_W-1:0] rx_q, rx_n, tx_q, tx_n, out_q, out_n;
  logic              miso_q, miso_n, oe_q, oe_n, trig_q, trig_n, ferr_q, ferr_n;

`ifdef SPI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_q, idle_n;
`else
  // The timeout limit only matters when the idle counter is built.
  localparam int TIMEOUT_CYC_UNUSED = TIMEOUT_CYC;
`endif

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(bus.spi_cs_n),
    .sync(cs_sync_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(bus.spi_sclk),
    .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  // MOSI needs the same depth as SCLK so data and clock edges stay aligned.
  always_ff @(posedge clk) begin
    if (rst) mosi_sr <= '0;
    else     mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], bus.spi_mosi};
  end
  assign mosi_s = mosi_sr[SYNC_STAGES-1];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      out_q   <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      trig_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef SPI_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      rx_q    <= rx_n;
      tx_q    <= tx_n;
      out_q   <= out_n;
      miso_q  <= miso_n;
      oe_q    <= oe_n;
      trig_q  <= trig_n;
      ferr_q  <= ferr_n;
`ifdef SPI_TIMEOUT_EN
      idle_q  <= idle_n;
`endif
    end
  end

  // Next-state and output logic: frame start, bit shifting, word completion, aborts.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rx_n    = rx_q;
    tx_n    = tx_q;
    out_n   = out_q;
    miso_n  = miso_q;
    oe_n    = oe_q;
    trig_n  = 1'b0;
    ferr_n  = 1'b0;
`ifdef SPI_TIMEOUT_EN
    idle_n  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          tx_n    = bus.spi_inputvalue;
          cnt_n   = '0;
          oe_n    = 1'b1;
          miso_n  = bus.spi_inputvalue[WORD_W-1];
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
`ifdef SPI_TIMEOUT_EN
        if (!sclk_rise && !sclk_fall && cnt_q != '0) idle_n = idle_q + TW'(1);
`endif
        if (sclk_rise) begin
          rx_n = {rx_q[WORD_W-2:0], mosi_s};
          if (cnt_q == LAST_BIT) begin
            out_n  = rx_n;
            trig_n = 1'b1;
            cnt_n  = '0;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
        if (sclk_fall) begin
          if (cnt_q != '0) begin
            tx_n   = {tx_q[WORD_W-2:0], 1'b0};
            miso_n = tx_q[WORD_W-2];
          end else begin
            // Word boundary: pick up the decoder's response for the next word.
            tx_n   = bus.spi_inputvalue;
            miso_n = bus.spi_inputvalue[WORD_W-1];
          end
        end
        // A CS rise on the completing SCLK rise still counts as a clean end.
        if (cs_rise) begin
          ferr_n  = (cnt_n != '0);
          cnt_n   = '0;
          oe_n    = 1'b0;
          miso_n  = 1'b0;
          state_n = IDLE;
        end
`ifdef SPI_TIMEOUT_EN
        else if (idle_n == TW'(TIMEOUT_CYC)) begin
          ferr_n  = 1'b1;
          cnt_n   = '0;
          oe_n    = 1'b0;
          miso_n  = 1'b0;
          state_n = WAIT_CS;
        end
`endif
      end
      WAIT_CS: begin
        oe_n   = 1'b0;
        miso_n = 1'b0;
        if (cs_rise) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.spi_miso           = miso_q;
  assign bus.spi_miso_oe        = oe_q;
  assign bus.spi_outputvalue    = out_q;
  assign bus.spi_dataouttrigger = trig_q;
  assign bus.frame_err          = ferr_q;

endmodule

// File: tb/tb_spi_word_slave.sv
// Directed bench for spi_word_slave: MCU-side SPI driver plus decoder-side word stimulus.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_spi_word_slave;
  import spi_word_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  spi_word_slave_if #(.WORD_W(W)) bus ();

  spi_word_slave #(.WORD_W(W), .SYNC_STAGES(2), .TIMEOUT_CYC(64)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int fails  = 0;
  int trig_cnt = 0;
  int ferr_cnt = 0;

  // Count output pulses in whole clk cycles, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.spi_dataouttrigger === 1'b1) trig_cnt++;
    if (bus.frame_err === 1'b1) ferr_cnt++;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift bits [31-first .. 31-first-nbits+1] of mo; SCLK falls, MOSI changes, SCLK rises.
  task automatic xfer(input logic [31:0] mo, input int first, input int nbits,
                      input bit cs_last, output logic [31:0] mi);
    mi = '0;
    for (int i = first; i < first + nbits; i++) begin
      bus.spi_sclk = 1'b0;
      bus.spi_mosi = mo[31-i];
      clks(5);
      bus.spi_sclk = 1'b1;
      if (cs_last && i == first + nbits - 1) bus.spi_cs_n = 1'b1;
      mi[31-i] = bus.spi_miso;
      clks(5);
    end
    clks(3);
  endtask

  task automatic begin_frame();
    bus.spi_cs_n = 1'b0;
    clks(6);
  endtask

  task automatic end_frame();
    bus.spi_sclk = 1'b0;
    clks(6);
    bus.spi_cs_n = 1'b1;
    clks(8);
  endtask

  task automatic test_reset();
    bus.spi_cs_n = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_inputvalue = '0;
    rst = 1'b1;
    clks(4);
    rst = 1'b0;
    clks(2);
    checks++; if (bus.spi_outputvalue !== 32'h0) begin fails++; $display("FAIL reset_out: got %h want %h", bus.spi_outputvalue, 32'h0); end
    checks++; if (bus.spi_dataouttrigger !== 1'b0) begin fails++; $display("FAIL reset_trig: got %b want 0", bus.spi_dataouttrigger); end
    checks++; if (bus.spi_miso !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b want 0", bus.spi_miso); end
    checks++; if (bus.spi_miso_oe !== 1'b0) begin fails++; $display("FAIL reset_oe: got %b want 0", bus.spi_miso_oe); end
    checks++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", bus.frame_err); end
  endtask

  task automatic test_single_frame();
    logic [31:0] mi;
    int t0, f0;
    bus.spi_inputvalue = 32'hDEADBEEF;
    t0 = trig_cnt; f0 = ferr_cnt;
    begin_frame();
    checks++; if (bus.spi_miso_oe !== 1'b1) begin fails++; $display("FAIL single_oe_on: got %b want 1", bus.spi_miso_oe); end
    xfer(32'h40001234, 0, 32, 1'b0, mi);
    checks++; if (bus.spi_outputvalue !== 32'h40001234) begin fails++; $display("FAIL single_out: got %h want %h", bus.spi_outputvalue, 32'h40001234); end
    checks++; if (trig_cnt - t0 != 1) begin fails++; $display("FAIL single_trig: got %0d want 1", trig_cnt - t0); end
    end_frame();
    checks++; if (mi !== 32'hDEADBEEF) begin fails++; $display("FAIL single_miso: got %h want %h", mi, 32'hDEADBEEF); end
    checks++; if (bus.spi_miso_oe !== 1'b0) begin fails++; $display("FAIL single_oe_off: got %b want 0", bus.spi_miso_oe); end
    checks++; if (bus.spi_miso !== 1'b0) begin fails++; $display("FAIL single_miso_idle: got %b want 0", bus.spi_miso); end
    checks++; if (ferr_cnt - f0 != 0) begin fails++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt - f0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] mi1, mi2;
    int t0;
    bus.spi_inputvalue = 32'h11111111;
    t0 = trig_cnt;
    begin_frame();
    xfer(32'h50000000, 0, 32, 1'b0, mi1);
    checks++; if (bus.spi_outputvalue !== 32'h50000000) begin fails++; $display("FAIL b2b_out1: got %h want %h", bus.spi_outputvalue, 32'h50000000); end
    checks++; if (trig_cnt - t0 != 1) begin fails++; $display("FAIL b2b_trig1: got %0d want 1", trig_cnt - t0); end
    bus.spi_inputvalue = 32'h00005AA5;
    xfer(32'h51000000, 0, 32, 1'b0, mi2);
    checks++; if (bus.spi_outputvalue !== 32'h51000000) begin fails++; $display("FAIL b2b_out2: got %h want %h", bus.spi_outputvalue, 32'h51000000); end
    checks++; if (trig_cnt - t0 != 2) begin fails++; $display("FAIL b2b_trig2: got %0d want 2", trig_cnt - t0); end
    end_frame();
    checks++; if (mi1 !== 32'h11111111) begin fails++; $display("FAIL b2b_miso1: got %h want %h", mi1, 32'h11111111); end
    checks++; if (mi2 !== 32'h00005AA5) begin fails++; $display("FAIL b2b_miso2: got %h want %h", mi2, 32'h00005AA5); end
  endtask

  task automatic test_abort();
    logic [31:0] mi;
    int t0, f0;
    t0 = trig_cnt; f0 = ferr_cnt;
    begin_frame();
    xfer(32'hFFFFFFFF, 0, 17, 1'b0, mi);
    end_frame();
    checks++; if (trig_cnt - t0 != 0) begin fails++; $display("FAIL abort_trig: got %0d want 0", trig_cnt - t0); end
    checks++; if (ferr_cnt - f0 != 1) begin fails++; $display("FAIL abort_ferr: got %0d want 1", ferr_cnt - f0); end
    checks++; if (bus.spi_outputvalue !== 32'h51000000) begin fails++; $display("FAIL abort_hold: got %h want %h", bus.spi_outputvalue, 32'h51000000); end
    t0 = trig_cnt;
    begin_frame();
    xfer(32'h12345678, 0, 32, 1'b0, mi);
    end_frame();
    checks++; if (bus.spi_outputvalue !== 32'h12345678) begin fails++; $display("FAIL abort_next_out: got %h want %h", bus.spi_outputvalue, 32'h12345678); end
    checks++; if (trig_cnt - t0 != 1) begin fails++; $display("FAIL abort_next_trig: got %0d want 1", trig_cnt - t0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] mi;
    int t0, f0;
    begin_frame();
    xfer(32'hAAAA5555, 0, 10, 1'b0, mi);
    rst = 1'b1;
    clks(3);
    rst = 1'b0;
    clks(1);
    checks++; if (bus.spi_outputvalue !== 32'h0) begin fails++; $display("FAIL rstmid_out: got %h want %h", bus.spi_outputvalue, 32'h0); end
    checks++; if (bus.spi_miso_oe !== 1'b0) begin fails++; $display("FAIL rstmid_oe: got %b want 0", bus.spi_miso_oe); end
    checks++; if (bus.spi_miso !== 1'b0) begin fails++; $display("FAIL rstmid_miso: got %b want 0", bus.spi_miso); end
    t0 = trig_cnt; f0 = ferr_cnt;
    // CS still low: a whole word of SCLK must be ignored.
    xfer(32'hFFFFFFFF, 0, 32, 1'b0, mi);
    bus.spi_sclk = 1'b0;
    clks(6);
    checks++; if (bus.spi_miso_oe !== 1'b0) begin fails++; $display("FAIL rstmid_oe_ignored: got %b want 0", bus.spi_miso_oe); end
    bus.spi_cs_n = 1'b1;
    clks(8);
    checks++; if (trig_cnt - t0 != 0) begin fails++; $display("FAIL rstmid_trig: got %0d want 0", trig_cnt - t0); end
    checks++; if (ferr_cnt - f0 != 0) begin fails++; $display("FAIL rstmid_ferr: got %0d want 0", ferr_cnt - f0); end
    checks++; if (bus.spi_outputvalue !== 32'h0) begin fails++; $display("FAIL rstmid_out_held: got %h want %h", bus.spi_outputvalue, 32'h0); end
    begin_frame();
    xfer(32'h05300000, 0, 32, 1'b0, mi);
    end_frame();
    checks++; if (bus.spi_outputvalue !== 32'h05300000) begin fails++; $display("FAIL rstmid_next_out: got %h want %h", bus.spi_outputvalue, 32'h05300000); end
  endtask

  task automatic test_timeout();
    logic [31:0] mi;
    int t0, f0;
    t0 = trig_cnt; f0 = ferr_cnt;
    begin_frame();
    xfer(32'hA5C30F96, 0, 8, 1'b0, mi);
    clks(100);
`ifdef SPI_TIMEOUT_EN
    checks++; if (ferr_cnt - f0 != 1) begin fails++; $display("FAIL timeout_ferr: got %0d want 1", ferr_cnt - f0); end
    checks++; if (bus.spi_miso_oe !== 1'b0) begin fails++; $display("FAIL timeout_oe: got %b want 0", bus.spi_miso_oe); end
`else
    checks++; if (ferr_cnt - f0 != 0) begin fails++; $display("FAIL timeout_ferr: got %0d want 0", ferr_cnt - f0); end
    checks++; if (bus.spi_miso_oe !== 1'b1) begin fails++; $display("FAIL timeout_oe: got %b want 1", bus.spi_miso_oe); end
`endif
    xfer(32'hA5C30F96, 8, 24, 1'b0, mi);
    end_frame();
`ifdef SPI_TIMEOUT_EN
    checks++; if (trig_cnt - t0 != 0) begin fails++; $display("FAIL timeout_trig: got %0d want 0", trig_cnt - t0); end
    checks++; if (bus.spi_outputvalue !== 32'h05300000) begin fails++; $display("FAIL timeout_out: got %h want %h", bus.spi_outputvalue, 32'h05300000); end
`else
    checks++; if (trig_cnt - t0 != 1) begin fails++; $display("FAIL timeout_trig: got %0d want 1", trig_cnt - t0); end
    checks++; if (bus.spi_outputvalue !== 32'hA5C30F96) begin fails++; $display("FAIL timeout_out: got %h want %h", bus.spi_outputvalue, 32'hA5C30F96); end
`endif
  endtask

  task automatic test_cs_coincident();
    logic [31:0] mi;
    int t0, f0;
    t0 = trig_cnt; f0 = ferr_cnt;
    begin_frame();
    xfer(32'h0F0F1234, 0, 32, 1'b1, mi);
    clks(8);
    checks++; if (trig_cnt - t0 != 1) begin fails++; $display("FAIL coinc_trig: got %0d want 1", trig_cnt - t0); end
    checks++; if (ferr_cnt - f0 != 0) begin fails++; $display("FAIL coinc_ferr: got %0d want 0", ferr_cnt - f0); end
    checks++; if (bus.spi_outputvalue !== 32'h0F0F1234) begin fails++; $display("FAIL coinc_out: got %h want %h", bus.spi_outputvalue, 32'h0F0F1234); end
    checks++; if (bus.spi_miso_oe !== 1'b0) begin fails++; $display("FAIL coinc_oe: got %b want 0", bus.spi_miso_oe); end
    bus.spi_sclk = 1'b0;
    clks(5);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_abort();
    test_reset_mid_frame();
    test_timeout();
    test_cs_coincident();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
